// File: rtl/gf_serial_mult.sv
// gf_serial_mult -- bit-serial GF(2^M) multiplier, MSB-first, one multiplier
// bit per clock.
//
// Optional feature macro: GF_MULT_ACC_EN.
//   When it is defined, the block adds an in_acc_clr port and an M-bit
//   accumulator. Each result is XORed into the accumulator.
//
// Parameters
//   M     field degree, which is also the operand and result width (2..32)
//   POLY  low M bits of the field polynomial; the x^M term is implicit
//
// Ports
//   clk         clock; all state updates on the rising edge
//   reset_      asynchronous active-low reset
//   in_valid    operand pair present
//   in_ready    operands accepted this cycle (high only in IDLE)
//   in_a/in_b   multiplicand / multiplier
//   in_acc_clr  start this operation from a zero accumulator (GF_MULT_ACC_EN only)
//   out_valid   result present (high only in DONE)
//   out_ready   consumer takes the result
//   out_y       product; zero outside DONE
//   busy        high in RUN or DONE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// RUN   | M shift-reduce-add steps, multiplier bit r_cnt is consumed
// DONE  | result held on out_y until out_ready
module gf_serial_mult #(
  parameter int              M    = 8,
  parameter logic [M-1:0]    POLY = 8'h1D
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
`ifdef GF_MULT_ACC_EN
  input  logic         in_acc_clr,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_y,
  output logic         busy
);

  localparam int CW = $clog2(M);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state;
  logic [M-1:0]   r_a;
  logic [M-1:0]   r_b;
  logic [M-1:0]   r_p;
  logic [CW-1:0]  r_cnt;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;
  logic [M-1:0]   r_out_y;

  logic [M-1:0]   w_p_next;
  logic [M-1:0]   w_result;

  // Horner step: multiply the partial product by x, reduce by the field
  // polynomial when x^M would appear, then add a if the current bit of b is set.
  assign w_p_next = {r_p[M-2:0], 1'b0}
                  ^ (r_p[M-1]   ? POLY : '0)
                  ^ (r_b[r_cnt] ? r_a  : '0);

`ifdef GF_MULT_ACC_EN
  logic [M-1:0]   r_acc;
  logic           r_clr;
  assign w_result = (r_clr ? '0 : r_acc) ^ w_p_next;
`else
  assign w_result = w_p_next;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_y     <= '0;
`ifdef GF_MULT_ACC_EN
      r_acc       <= '0;
      r_clr       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_p        <= '0;
            r_cnt      <= CW'(M - 1);
`ifdef GF_MULT_ACC_EN
            r_clr      <= in_acc_clr;
`endif
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_p <= w_p_next;
          if (r_cnt == '0) begin
            // The result is registered on the last step, so out_y is valid
            // in the same cycle that out_valid rises.
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_y     <= w_result;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
`ifdef GF_MULT_ACC_EN
            r_acc       <= r_out_y;
`endif
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_y     <= '0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign busy      = r_busy;

endmodule
